// File: rtl/cmd_entry.sv
// cmd_entry: button/switch command producer with two-half operand assembly and timeout auto-push
module cmd_entry #(
    parameter int SW_W    = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 100_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SW_W-1:0]   switches,
    input  logic [4:0]        btn_db,
    input  logic              cmd_ready,
    output logic              cmd_valid,
    output logic              cmd_push,
    output logic [DATA_W-1:0] cmd_data,
    output logic [3:0]        cmd_op,
    output logic [DATA_W-1:0] entry_val,
    output logic              hi_pending
);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, LO_HELD, SEND} state_t;
    state_t            state_q, state_d;
    logic [4:0]        btn_prev_q;
    logic [4:0]        rise;
    logic [3:0]        op_sel;
    logic [TW-1:0]     timer_q, timer_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              cmd_push_q, cmd_push_d;
    logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
    logic [3:0]        cmd_op_q, cmd_op_d;
    logic [DATA_W-1:0] entry_val_q, entry_val_d;
    logic              hi_pending_q, hi_pending_d;
    logic              commit;
    logic [DATA_W-1:0] commit_val;
    assign rise   = btn_db & ~btn_prev_q;
    assign op_sel = rise[1] ? 4'b0001 : rise[2] ? 4'b0010 : rise[3] ? 4'b0100 : rise[4] ? 4'b1000 : 4'b0000;
    assign commit = rise[0] || timer_q == TW'(TIMEOUT - 1);
    // an explicit enter supplies the high half; a timeout leaves it zero
    assign commit_val = {rise[0] ? switches : {SW_W{1'b0}}, entry_val_q[SW_W-1:0]};
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        cmd_valid_d  = cmd_valid_q;
        cmd_push_d   = cmd_push_q;
        cmd_data_d   = cmd_data_q;
        cmd_op_d     = cmd_op_q;
        entry_val_d  = entry_val_q;
        hi_pending_d = hi_pending_q;
        case (state_q)
            IDLE: begin
                if (rise[0]) begin
                    entry_val_d  = {{(DATA_W - SW_W){1'b0}}, switches};
                    hi_pending_d = 1'b1;
                    timer_d      = '0;
                    state_d      = LO_HELD;
                end else if (|rise[4:1]) begin
                    cmd_op_d    = op_sel;
                    cmd_push_d  = 1'b0;
                    cmd_data_d  = '0;
                    cmd_valid_d = 1'b1;
                    state_d     = SEND;
                end
            end
            LO_HELD: begin
                timer_d = timer_q + 1'b1;
                if (commit) begin
                    entry_val_d  = commit_val;
                    cmd_data_d   = commit_val;
                    cmd_push_d   = 1'b1;
                    cmd_op_d     = 4'b0000;
                    cmd_valid_d  = 1'b1;
                    hi_pending_d = 1'b0;
                    state_d      = SEND;
                end
            end
            SEND: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    cmd_push_d  = 1'b0;
                    cmd_data_d  = '0;
                    cmd_op_d    = 4'b0000;
                    entry_val_d = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            btn_prev_q   <= '0;
            timer_q      <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_push_q   <= 1'b0;
            cmd_data_q   <= '0;
            cmd_op_q     <= '0;
            entry_val_q  <= '0;
            hi_pending_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            btn_prev_q   <= btn_db;
            timer_q      <= timer_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_push_q   <= cmd_push_d;
            cmd_data_q   <= cmd_data_d;
            cmd_op_q     <= cmd_op_d;
            entry_val_q  <= entry_val_d;
            hi_pending_q <= hi_pending_d;
        end
    end
    assign cmd_valid  = cmd_valid_q;
    assign cmd_push   = cmd_push_q;
    assign cmd_data   = cmd_data_q;
    assign cmd_op     = cmd_op_q;
    assign entry_val  = entry_val_q;
    assign hi_pending = hi_pending_q;
endmodule

// File: tb/tb_cmd_entry.sv
// tb_cmd_entry: directed scenarios plus random buttons/switches/ready against a command-level reference model
module tb_cmd_entry;
    localparam int TO = 10;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] switches;
    logic [4:0]  btn_db;
    logic        cmd_ready;
    logic        cmd_valid, cmd_push, hi_pending;
    logic [31:0] cmd_data, entry_val;
    logic [3:0]  cmd_op;
    int vectors = 0;
    int miscompares = 0;
    int mode, cyc, cap;
    logic [4:0]  m_prev;
    logic [15:0] m_lo;
    logic        e_valid, e_push, e_hi;
    logic [31:0] e_data, e_entry;
    logic [3:0]  e_op;
    int accepts;
    cmd_entry #(.SW_W(16), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .switches(switches), .btn_db(btn_db), .cmd_ready(cmd_ready),
        .cmd_valid(cmd_valid), .cmd_push(cmd_push), .cmd_data(cmd_data), .cmd_op(cmd_op),
        .entry_val(entry_val), .hi_pending(hi_pending)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask
    task automatic model_step();
        logic [4:0] r;
        if (!rst) begin
            mode = 0; m_prev = '0; m_lo = '0;
            e_valid = 0; e_push = 0; e_hi = 0; e_data = '0; e_entry = '0; e_op = '0;
        end else begin
            r = btn_db & ~m_prev;
            m_prev = btn_db;
            if (mode == 0) begin
                if (r[0]) begin
                    m_lo = switches; e_entry = {16'h0, switches}; e_hi = 1; cap = cyc; mode = 1;
                end else if (r[4:1] != 0) begin
                    for (int i = 4; i >= 1; i--) if (r[i]) e_op = 4'(1 << (i - 1));
                    e_push = 0; e_data = '0; e_valid = 1; mode = 2;
                end
            end else if (mode == 1) begin
                if (r[0] || cyc - cap == TO) begin
                    e_data = {r[0] ? switches : 16'h0, m_lo};
                    e_entry = e_data; e_push = 1; e_op = '0; e_valid = 1; e_hi = 0; mode = 2;
                end
            end else if (cmd_ready) begin
                e_valid = 0; e_entry = '0; mode = 0;
            end
        end
        cyc++;
    endtask
    task automatic tick();
        @(posedge clk);
        if (cmd_valid && cmd_ready && rst) accepts++;
        model_step();
        #1;
        chk("valid", 64'(cmd_valid), 64'(e_valid));
        chk("hi_pending", 64'(hi_pending), 64'(e_hi));
        chk("entry_val", 64'(entry_val), 64'(e_entry));
        if (e_valid) begin
            chk("push", 64'(cmd_push), 64'(e_push));
            chk("data", 64'(cmd_data), 64'(e_data));
            chk("op", 64'(cmd_op), 64'(e_op));
        end
    endtask
    initial begin
        cyc = 0; cap = 0; mode = 0; m_prev = '0; accepts = 0;
        rst = 0; btn_db = '0; switches = '0; cmd_ready = 0;
        for (int i = 0; i < 3; i++) begin
            btn_db = 5'(i * 7 + 1); switches = 16'(i * 16'h1111 + 16'h0F0F);
            tick();
        end
        chk("rst_valid", 64'(cmd_valid), 0);
        chk("rst_entry", 64'(entry_val), 0);
        chk("rst_hi", 64'(hi_pending), 0);
        chk("rst_data", 64'(cmd_data), 0);
        chk("rst_op", 64'(cmd_op), 0);
        rst = 1; btn_db = '0; switches = '0;
        tick();
        switches = 16'h1234; btn_db = 5'b00001; tick();
        chk("t2_hi", 64'(hi_pending), 1);
        chk("t2_entry_lo", 64'(entry_val), 64'h0000_1234);
        btn_db = '0; tick();
        switches = 16'hABCD; btn_db = 5'b00001; tick();
        chk("t2_valid", 64'(cmd_valid), 1);
        chk("t2_push", 64'(cmd_push), 1);
        chk("t2_data", 64'(cmd_data), 64'hABCD_1234);
        cmd_ready = 1; btn_db = '0; tick();
        chk("t2_drop", 64'(cmd_valid), 0);
        chk("t2_entry_clr", 64'(entry_val), 0);
        cmd_ready = 0;
        btn_db = 5'b01000; tick();
        for (int i = 0; i < 5; i++) begin
            btn_db = (i == 2) ? 5'b00001 : 5'b00000;
            tick();
            chk("t3_stall_valid", 64'(cmd_valid), 1);
            chk("t3_stall_op", 64'(cmd_op), 64'b0100);
        end
        cmd_ready = 1; btn_db = '0; tick();
        chk("t3_accept", 64'(cmd_valid), 0);
        cmd_ready = 0;
        for (int i = 0; i < 3; i++) tick();
        chk("t3_no_push", 64'(cmd_valid), 0);
        chk("t3_no_hi", 64'(hi_pending), 0);
        btn_db = 5'b10100; tick();
        chk("t4_op", 64'(cmd_op), 64'b0010);
        cmd_ready = 1; btn_db = '0; tick();
        cmd_ready = 0;
        btn_db = 5'b00011; tick();
        chk("t4_hi", 64'(hi_pending), 1);
        chk("t4_no_cmd", 64'(cmd_valid), 0);
        btn_db = '0;
        for (int i = 0; i < 12; i++) tick();
        cmd_ready = 1; tick(); cmd_ready = 0; tick();
        switches = 16'h00FF; btn_db = 5'b00001; tick();
        btn_db = '0; switches = 16'hFFFF;
        for (int j = 1; j <= TO; j++) begin
            btn_db = (j == 3) ? 5'b00100 : 5'b00000;
            tick();
            if (j < TO) chk("t5_wait", 64'(cmd_valid), 0);
        end
        chk("t5_valid", 64'(cmd_valid), 1);
        chk("t5_data", 64'(cmd_data), 64'h0000_00FF);
        chk("t5_push", 64'(cmd_push), 1);
        cmd_ready = 1; btn_db = '0; tick();
        chk("t5_done", 64'(cmd_valid), 0);
        accepts = 0;
        switches = 16'h5555; btn_db = 5'b00001;
        for (int i = 0; i < 50; i++) tick();
        chk("t6_one_cmd", 64'(accepts), 1);
        chk("t6_idle", 64'(hi_pending), 0);
        btn_db = '0; cmd_ready = 0; tick();
        switches = 16'h7777; btn_db = 5'b00001; tick();
        btn_db = '0; tick(); tick();
        chk("t6_pending", 64'(hi_pending), 1);
        rst = 0; tick();
        chk("t6_rst_hi", 64'(hi_pending), 0);
        chk("t6_rst_entry", 64'(entry_val), 0);
        rst = 1;
        for (int i = 0; i < 2 * TO; i++) tick();
        chk("t6_no_cmd", 64'(cmd_valid), 0);
        for (int i = 0; i < 3000; i++) begin
            btn_db = btn_db ^ 5'($urandom & $urandom & $urandom);
            switches = 16'($urandom);
            cmd_ready = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 299) != 0);
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cmd_entry.md
Name: cmd_entry

Overview:
- Input-side command generator for the stack/queue calculator; it is the producer end of the command interface the memory controller consumes.
- Turns debounced button levels and the 16 slide switches into one-shot push and ALU-op commands on a valid/ready handshake.
- Assembles 32-bit operands from two 16-bit switch captures, with a timeout auto-commit.
- Exports the in-progress operand for display on the seven-segment driver.

Parameters:
SW_W, 16, switch bus width (one operand half)
DATA_W, 32, command data width; must equal 2*SW_W
TIMEOUT, 100_000_000, idle cycles in LO_HELD before an auto-push of the zero-extended low half (1 s at 100 MHz)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-low reset
switches  input  SW_W  operand half to capture
btn_db  input  5  debounced buttons; [0]=enter, [4:1]=ALU op select
cmd_ready  input  1  consumer accepts the command when cmd_valid is also high
cmd_valid  output  1  command present
cmd_push  output  1  1=push cmd_data, 0=ALU op cmd_op
cmd_data  output  DATA_W  operand for push, 0 for op commands
cmd_op  output  4  one-hot op for op commands, 0 for push
entry_val  output  DATA_W  operand being assembled (display tap)
hi_pending  output  1  low half captured, awaiting high half

Behaviour:
- Reset (rst==0 at posedge clk):
  - Clears all outputs, the button-edge registers and the timeout counter.
  - State returns to IDLE.
  - Reset mid-operation discards any partial operand and any unaccepted command.
- Edge detect:
  - btn_prev <= btn_db every cycle.
  - rise = btn_db & ~btn_prev.
  - Only rising edges act. Held buttons produce exactly one event.
- FSM states: IDLE, LO_HELD, SEND.
- IDLE:
  - rise[0] takes priority over op buttons in the same cycle. It sets entry_val[15:0]=switches, entry_val[31:16]=0, hi_pending=1, timer=0, and goes to LO_HELD.
  - Otherwise, if any of rise[4:1] is set, the lowest index wins: cmd_op=onehot(index), cmd_push=0, cmd_data=0, cmd_valid=1, go to SEND.
- LO_HELD:
  - The timer increments each cycle.
  - rise[0]: entry_val[31:16]=switches, cmd_data={switches, low half}, cmd_push=1, cmd_op=0, cmd_valid=1, hi_pending=0, go to SEND.
  - timer==TIMEOUT-1 with no rise[0]: auto-push cmd_data={16'h0, low half} with the same output updates, go to SEND.
  - rise[4:1]: ignored.
- SEND:
  - cmd_valid stays high and cmd_push/cmd_data/cmd_op are stable until a cycle with cmd_ready=1.
  - In that cycle the handshake completes. Next cycle: cmd_valid=0, entry_val=0, state IDLE.
  - All button edges arriving in SEND are dropped (no queueing). btn_prev still tracks, so a button still held after SEND does not re-fire.
- cmd_ready high while cmd_valid=0 has no effect. The consumer may hold cmd_ready high permanently, which gives one command per press with a 1-cycle valid pulse.
- Latency: button rising edge at cycle N (btn_db sampled) gives cmd_valid high from cycle N+1.
- No combinational path from cmd_ready to any output; all outputs are registered.

Test Plan:
1. Reset: rst=0 for 3 cycles with buttons and switches toggling -> all outputs 0 and state IDLE on release.
2. Two-half push: switches=16'h1234, pulse btn0 -> hi_pending=1, entry_val=32'h0000_1234. Then switches=16'hABCD, pulse btn0 -> cmd_valid=1, cmd_push=1, cmd_data=32'hABCD_1234. With cmd_ready=1, cmd_valid drops the next cycle.
3. Op with backpressure: press btn[3] with cmd_ready=0 for 5 cycles -> cmd_op=4'b0100, cmd_valid held and stable. btn0 pressed during the stall is dropped (no later push). Raise cmd_ready -> one accept, then IDLE.
4. Simultaneous edges: btn[2] and btn[4] rise in the same IDLE cycle -> cmd_op=4'b0010. btn[0] with btn[1] in IDLE -> LO_HELD, no op command.
5. Timeout (bench TIMEOUT=10): capture 16'h00FF, no further presses -> auto-push cmd_data=32'h0000_00FF on cycle 10 after capture. An op press while in LO_HELD is ignored.
6. Held button and reset mid-entry: hold btn0 for 50 cycles -> single capture only. Assert rst while in LO_HELD -> hi_pending=0, entry_val=0, no command emitted.
